// File: rtl/dw_mac_frame_pipe_if.sv
// Operand/result handshake bundle for dw_mac_frame_pipe.
interface dw_mac_frame_pipe_if #(
    parameter int A_WIDTH   = 6,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic [A_WIDTH-1:0]   inst_a;
    logic [B_WIDTH-1:0]   inst_b;
    logic [OUT_WIDTH-1:0] inst_c;
    logic                 inst_tc;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] accum_out;
    logic                 ovf_out;

    modport master (
        output in_valid, inst_a, inst_b, inst_c, inst_tc, out_ready,
        input  in_ready, out_valid, accum_out, ovf_out
    );

    modport slave (
        input  in_valid, inst_a, inst_b, inst_c, inst_tc, out_ready,
        output in_ready, out_valid, accum_out, ovf_out
    );
endinterface

// File: rtl/dw_mac_frame_pipe.sv
// Pipelined frame MAC: stage 1 multiplies, stage 2 accumulates onto the frame's c,
// a held output register presents one result (plus sticky overflow) per frame.
module dw_mac_frame_pipe #(
    parameter int A_WIDTH   = 6,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18,
    parameter int ACC_LEN   = 4,
    parameter int SAT_EN    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    dw_mac_frame_pipe_if.slave  bus,
    output logic                busy
);
    localparam int P_W = A_WIDTH + B_WIDTH;
    localparam logic [15:0] CNT_LAST = 16'(ACC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state, state_nxt;

    logic [15:0]          cnt, cnt_nxt;
    logic                 first_beat, last_beat, beat_tc, accept;
    logic [P_W-1:0]       a_ext, b_ext, prod;
    logic                 frame_tc;
    logic                 s1_valid, s1_first, s1_last, s1_tc;
    logic [P_W-1:0]       s1_prod;
    logic [OUT_WIDTH-1:0] s1_c;
    logic                 s2_valid, s2_last;
    logic [OUT_WIDTH-1:0] acc, acc_nxt, base;
    logic                 ovf, ovf_now;
    logic [OUT_WIDTH:0]   base_ext, prod_ext, sum;
    logic [OUT_WIDTH-1:0] accum_q;
    logic                 ovf_q;
    logic                 out_valid, out_blocked, out_load;
    logic                 s1_stall, s2_stall, s1_valid_nxt, s2_valid_nxt;

    // Stage 2 also holds a completed last beat until the output register is free;
    // with ACC_LEN=1 two last beats can be in stage 1 and stage 2 at once.
    always_comb begin
        out_valid    = (state == HOLD);
        out_blocked  = out_valid && !bus.out_ready;
        s2_stall     = out_blocked && ((s1_valid && s1_last) || (s2_valid && s2_last));
        s1_stall     = s1_valid && s2_stall;
        bus.in_ready = clr || !s1_stall;
        accept       = bus.in_valid && bus.in_ready && !clr;
        first_beat   = (cnt == '0);
        last_beat    = (cnt == CNT_LAST);
        beat_tc      = first_beat ? bus.inst_tc : frame_tc;
        out_load     = s2_valid && s2_last && !out_blocked;
        cnt_nxt      = cnt;
        if (accept)
            cnt_nxt = last_beat ? '0 : cnt + 16'd1;
        s1_valid_nxt = s1_stall || accept;
        s2_valid_nxt = s2_stall ? s2_valid : s1_valid;
        busy         = (cnt != '0) || s1_valid || s2_valid;
    end

    always_comb begin
        a_ext = beat_tc ? {{B_WIDTH{bus.inst_a[A_WIDTH-1]}}, bus.inst_a}
                        : {{B_WIDTH{1'b0}}, bus.inst_a};
        b_ext = beat_tc ? {{A_WIDTH{bus.inst_b[B_WIDTH-1]}}, bus.inst_b}
                        : {{A_WIDTH{1'b0}}, bus.inst_b};
        prod  = a_ext * b_ext;
    end

    // One extra bit of headroom makes overflow visible in the top two sum bits.
    always_comb begin
        base     = s1_first ? s1_c : acc;
        base_ext = {s1_tc & base[OUT_WIDTH-1], base};
        prod_ext = {{(OUT_WIDTH + 1 - P_W){s1_tc & s1_prod[P_W-1]}}, s1_prod};
        sum      = base_ext + prod_ext;
        ovf_now  = s1_tc ? (sum[OUT_WIDTH] != sum[OUT_WIDTH-1]) : sum[OUT_WIDTH];
        acc_nxt  = sum[OUT_WIDTH-1:0];
        if (ovf_now && SAT_EN != 0) begin
            if (s1_tc && sum[OUT_WIDTH])
                acc_nxt = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            else
                acc_nxt = {!s1_tc, {(OUT_WIDTH - 1){1'b1}}};
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = IDLE;
        else if (out_load || out_blocked)
            state_nxt = HOLD;
        else if (cnt_nxt != '0 || s1_valid_nxt || s2_valid_nxt)
            state_nxt = ACCUM;
        else
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            frame_tc <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_tc    <= 1'b0;
            s1_prod  <= '0;
            s1_c     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
            accum_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            s1_valid <= s1_valid_nxt;
            s2_valid <= s2_valid_nxt;
            if (accept) begin
                s1_prod  <= prod;
                s1_first <= first_beat;
                s1_last  <= last_beat;
                s1_tc    <= beat_tc;
                if (first_beat) begin
                    s1_c     <= bus.inst_c;
                    frame_tc <= bus.inst_tc;
                end
            end
            if (s1_valid && !s2_stall) begin
                acc     <= acc_nxt;
                ovf     <= (ovf && !s1_first) || ovf_now;
                s2_last <= s1_last;
            end
            if (out_load) begin
                accum_q <= acc;
                ovf_q   <= ovf;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.accum_out = accum_q;
    assign bus.ovf_out   = ovf_q;
endmodule

// File: tb/tb_dw_mac_frame_pipe.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_dw_mac_frame_pipe;
    localparam int AW = 6;
    localparam int BW = 8;
    localparam int OW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic busy0, busy1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic tc = 1'b0;
    logic [AW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic [OW-1:0] c = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [OW:0] q0[$];
    logic [OW:0] q1[$];

    always #5 clk = ~clk;

    dw_mac_frame_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus0 ();
    dw_mac_frame_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus1 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
    assign bus0.inst_a = a;           assign bus1.inst_a = a;
    assign bus0.inst_b = b;           assign bus1.inst_b = b;
    assign bus0.inst_c = c;           assign bus1.inst_c = c;
    assign bus0.inst_tc = tc;         assign bus1.inst_tc = tc;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    dw_mac_frame_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .ACC_LEN(4), .SAT_EN(0))
        dut_wrap (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0), .busy(busy0));
    dw_mac_frame_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .ACC_LEN(4), .SAT_EN(1))
        dut_sat (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1), .busy(busy1));

    // Results handed over at the coming edge, as {ovf_out, accum_out}.
    always @(negedge clk) begin
        if (rst_n && !clr && bus0.out_valid && bus0.out_ready) q0.push_back({bus0.ovf_out, bus0.accum_out});
        if (rst_n && !clr && bus1.out_valid && bus1.out_ready) q1.push_back({bus1.ovf_out, bus1.accum_out});
    end

    task automatic send_beat(output int waits);
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus0.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [AW-1:0] fa, input logic [BW-1:0] fb,
                              input logic [OW-1:0] fc, input logic ftc, output int waits);
        int w;
        a = fa; b = fb; c = fc; tc = ftc;
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(w);
            waits += w;
        end
    endtask

    task automatic wait_result(output logic got, output logic [OW:0] r0, output logic [OW:0] r1);
        int n = 0;
        while ((q0.size() == 0 || q1.size() == 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        got = (q0.size() != 0) && (q1.size() != 0);
        r0 = '0;
        r1 = '0;
        if (got) begin
            r0 = q0.pop_front();
            r1 = q1.pop_front();
        end
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.accum_out !== 18'd0) begin miscompares++; $display("FAIL reset_accum got %0d want 0", bus0.accum_out); end
        vectors++; if (bus0.ovf_out !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", bus0.ovf_out); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
    endtask

    task automatic test_unsigned();
        int w;
        flush();
        send_frame(6'd63, 8'd255, 18'd0, 1'b0, w);
        vectors++; if (w != 0) begin miscompares++; $display("FAIL uns_accept_waits got %0d want 0", w); end
        vectors++; if (bus0.out_valid !== 1'b0 || busy0 !== 1'b1) begin miscompares++; $display("FAIL uns_n1 out_valid/busy got %b/%b want 0/1", bus0.out_valid, busy0); end
        @(posedge clk); #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL uns_n2_early got %b want 0", bus0.out_valid); end
        @(posedge clk); #1;
        vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL uns_latency out_valid got %b want 1", bus0.out_valid); end
        vectors++; if (bus0.accum_out !== 18'd64260 || bus0.ovf_out !== 1'b0) begin miscompares++; $display("FAIL uns_result got %0d ovf %b want 64260 ovf 0", bus0.accum_out, bus0.ovf_out); end
        @(posedge clk); #1;
        vectors++; if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL uns_pulse out_valid/busy got %b/%b want 0/0", bus0.out_valid, busy0); end
    endtask

    task automatic test_signed();
        int w;
        logic got;
        logic [OW:0] r0, r1;
        flush();
        send_frame(6'h20, 8'h80, 18'h3FFFF, 1'b1, w);
        send_frame(6'd1, 8'd1, 18'd5, 1'b0, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd16383} || r1 !== {1'b0, 18'd16383}) begin miscompares++; $display("FAIL signed_result got %0b {ovf,acc}=%h/%h want %h", got, r0, r1, {1'b0, 18'd16383}); end
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd9} || r1 !== {1'b0, 18'd9}) begin miscompares++; $display("FAIL mode_switch_result got %0b {ovf,acc}=%h/%h want %h", got, r0, r1, {1'b0, 18'd9}); end
    endtask

    task automatic test_overflow();
        int w;
        logic got;
        logic [OW:0] r0, r1;
        flush();
        send_frame(6'd63, 8'd255, 18'd262000, 1'b0, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b1, 18'd64116}) begin miscompares++; $display("FAIL uovf_wrap got %0b {ovf,acc}=%h want %h", got, r0, {1'b1, 18'd64116}); end
        vectors++; if (!got || r1 !== {1'b1, 18'd262143}) begin miscompares++; $display("FAIL uovf_sat got %0b {ovf,acc}=%h want %h", got, r1, {1'b1, 18'd262143}); end
        send_frame(6'h20, 8'h7F, 18'h20000, 1'b1, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b1, 18'd114816}) begin miscompares++; $display("FAIL sovf_wrap got %0b {ovf,acc}=%h want %h", got, r0, {1'b1, 18'd114816}); end
        vectors++; if (!got || r1 !== {1'b1, 18'd131072}) begin miscompares++; $display("FAIL sovf_sat got %0b {ovf,acc}=%h want %h", got, r1, {1'b1, 18'd131072}); end
        send_frame(6'd63, 8'd255, 18'd0, 1'b0, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd64260} || r1 !== {1'b0, 18'd64260}) begin miscompares++; $display("FAIL ovf_cleared got %0b {ovf,acc}=%h/%h want %h", got, r0, r1, {1'b0, 18'd64260}); end
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        logic got;
        logic [OW:0] r0, r1;
        flush();
        out_ready = 1'b0;
        send_frame(6'd1, 8'd1, 18'd100, 1'b0, w1);
        send_frame(6'd1, 8'd1, 18'd200, 1'b0, w2);
        vectors++; if (w1 != 0 || w2 != 0) begin miscompares++; $display("FAIL bp_early_stall waits got %0d/%0d want 0/0", w1, w2); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1 || bus0.accum_out !== 18'd104) begin miscompares++; $display("FAIL bp_hold in_ready/out_valid/acc got %b/%b/%0d want 0/1/104", bus0.in_ready, bus0.out_valid, bus0.accum_out); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd104}) begin miscompares++; $display("FAIL bp_first got %0b {ovf,acc}=%h want %h", got, r0, {1'b0, 18'd104}); end
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd204}) begin miscompares++; $display("FAIL bp_second got %0b {ovf,acc}=%h want %h", got, r0, {1'b0, 18'd204}); end
        repeat (6) begin @(posedge clk); #1; end
        vectors++; if (q0.size() != 0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL bp_extra results/busy got %0d/%b want 0/0", q0.size(), busy0); end
    endtask

    task automatic test_clr();
        int w;
        logic got;
        logic [OW:0] r0, r1;
        flush();
        a = 6'd5; b = 8'd5; c = 18'd1000; tc = 1'b0;
        send_beat(w);
        send_beat(w);
        in_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL clr_in_ready got %b want 1", bus0.in_ready); end
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        vectors++; if (busy0 !== 1'b0 || bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_flush busy/out_valid got %b/%b want 0/0", busy0, bus0.out_valid); end
        send_frame(6'd1, 8'd2, 18'd10, 1'b0, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd18}) begin miscompares++; $display("FAIL clr_next_frame got %0b {ovf,acc}=%h want %h", got, r0, {1'b0, 18'd18}); end
        repeat (6) begin @(posedge clk); #1; end
        vectors++; if (q0.size() != 0) begin miscompares++; $display("FAIL clr_stray_result got %0d want 0", q0.size()); end
        out_ready = 1'b0;
        send_frame(6'd1, 8'd1, 18'd7, 1'b0, w);
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (bus0.out_valid !== 1'b1 || bus0.accum_out !== 18'd11) begin miscompares++; $display("FAIL clr_pre_hold out_valid/acc got %b/%0d want 1/11", bus0.out_valid, bus0.accum_out); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        out_ready = 1'b1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_drop out_valid got %b want 0", bus0.out_valid); end
        repeat (5) begin @(posedge clk); #1; end
        vectors++; if (q0.size() != 0) begin miscompares++; $display("FAIL clr_dropped_result got %0d want 0", q0.size()); end
    endtask

    task automatic test_reset_mid();
        int w;
        logic got;
        logic [OW:0] r0, r1;
        flush();
        out_ready = 1'b0;
        send_frame(6'd1, 8'd1, 18'd100, 1'b0, w);
        a = 6'd3; b = 8'd3; c = 18'd50;
        send_beat(w);
        send_beat(w);
        vectors++; if (bus0.out_valid !== 1'b1 || busy0 !== 1'b1) begin miscompares++; $display("FAIL rst_pre out_valid/busy got %b/%b want 1/1", bus0.out_valid, busy0); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b0 || bus0.accum_out !== 18'd0 || bus0.ovf_out !== 1'b0) begin miscompares++; $display("FAIL rst_async out_valid/acc/ovf got %b/%0d/%b want 0/0/0", bus0.out_valid, bus0.accum_out, bus0.ovf_out); end
        vectors++; if (busy0 !== 1'b0 || bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_async busy/in_ready got %b/%b want 0/1", busy0, bus0.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        flush();
        send_frame(6'd1, 8'd2, 18'd10, 1'b0, w);
        wait_result(got, r0, r1);
        vectors++; if (!got || r0 !== {1'b0, 18'd18}) begin miscompares++; $display("FAIL rst_next_frame got %0b {ovf,acc}=%h want %h", got, r0, {1'b0, 18'd18}); end
        repeat (6) begin @(posedge clk); #1; end
        vectors++; if (q0.size() != 0) begin miscompares++; $display("FAIL rst_stray_result got %0d want 0", q0.size()); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
